// File: rtl/ahbl_i2s_tx_pkg.sv
// ==== ahbl_i2s_tx_pkg : register map, frame constants and serializer state type (rev 1.0) ====
`default_nettype none

package ahbl_i2s_tx_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_DATA     = 8'h08;
  localparam logic [7:0] OFF_PRESCALE = 8'h0C;
  localparam logic [7:0] OFF_THRESH   = 8'h10;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_MONO   = 1;
  localparam int CTRL_FLUSH  = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int BIDX_W     = $clog2(FRAME_BITS);

  localparam logic [BIDX_W-1:0] B_RIGHT = BIDX_W'(SLOT_BITS);
  localparam logic [31:0]       RD_DEFAULT = 32'hBADDBEEF;

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_RUN  = 2'd1,
    SER_STOP = 2'd2
  } ser_state_t;

  // WS leads the data by one bit clock, so it spans slots 31..62
  function automatic logic ws_for_slot(input logic [BIDX_W-1:0] b);
    return (b >= BIDX_W'(SLOT_BITS - 1)) && (b <= BIDX_W'(FRAME_BITS - 2));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahbl_i2s_tx_serializer.sv
// ==== i2s_tx_serializer : SCK/WS generation and MSB-first shift-out of stereo/mono frames (rev 1.0) ====
`default_nettype none

module i2s_tx_serializer
  import ahbl_i2s_tx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mono,
  input  logic [7:0]           presc,
  input  logic                 fifo_empty,
  input  logic [SLOT_BITS-1:0] fifo_word,
  output logic                 pop,
  output logic                 underrun,
  output logic                 sck,
  output logic                 ws,
  output logic                 sd
);

  ser_state_t           state;
  ser_state_t           state_nx;
  logic [7:0]           cnt;
  logic [7:0]           presc_lat;
  logic [BIDX_W-1:0]    bidx;
  logic [BIDX_W-1:0]    bidx_nx;
  logic                 started;
  logic                 sck_r;
  logic                 ws_r;
  logic                 sd_r;
  logic [SLOT_BITS-1:0] shreg;
  logic [SLOT_BITS-1:0] left_r;
  logic [SLOT_BITS-1:0] word_nx;
  logic                 tc;
  logic                 fall;
  logic                 frame_start;
  logic                 load_left;
  logic                 load_right;
  logic                 need_word;

  assign tc          = (state != SER_IDLE) && (cnt == presc_lat);
  assign fall        = (state == SER_RUN) && tc && sck_r;
  assign bidx_nx     = started ? bidx + 1'b1 : '0;
  assign frame_start = fall && (bidx_nx == '0);
  assign load_left   = frame_start && en;
  assign load_right  = fall && started && (bidx_nx == B_RIGHT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SER_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SER_IDLE: if (en) state_nx = SER_RUN;
      SER_RUN:  if (frame_start && !en) state_nx = SER_STOP;
      SER_STOP: if (tc) state_nx = SER_IDLE;
      default:  state_nx = SER_IDLE;
    endcase
  end

  always_comb begin
    need_word = load_left | (load_right & ~mono);
    pop       = need_word & ~fifo_empty;
    underrun  = need_word & fifo_empty;
    if (load_right && mono) word_nx = left_r;
    else if (fifo_empty)    word_nx = '0;
    else                    word_nx = fifo_word;
  end

  // Outputs only move on SCK falling edges so the DAC sees stable data on rising
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      presc_lat <= '0;
      sck_r     <= 1'b0;
      bidx      <= '0;
      started   <= 1'b0;
      ws_r      <= 1'b0;
      sd_r      <= 1'b0;
      shreg     <= '0;
      left_r    <= '0;
    end else if (state == SER_IDLE) begin
      cnt       <= '0;
      presc_lat <= presc;
      sck_r     <= 1'b0;
      bidx      <= '0;
      started   <= 1'b0;
      ws_r      <= 1'b0;
      sd_r      <= 1'b0;
    end else begin
      if (tc) begin
        cnt       <= '0;
        presc_lat <= presc;
        sck_r     <= (state == SER_RUN) ? ~sck_r : 1'b0;
      end else begin
        cnt <= cnt + 8'd1;
      end
      if (fall) begin
        if (frame_start && !en) begin
          ws_r <= 1'b0;
          sd_r <= 1'b0;
        end else begin
          bidx    <= bidx_nx;
          started <= 1'b1;
          ws_r    <= ws_for_slot(bidx_nx);
          if (load_left || load_right) begin
            sd_r  <= word_nx[SLOT_BITS-1];
            shreg <= {word_nx[SLOT_BITS-2:0], 1'b0};
          end else begin
            sd_r  <= shreg[SLOT_BITS-1];
            shreg <= {shreg[SLOT_BITS-2:0], 1'b0};
          end
          if (load_left) left_r <= word_nx;
        end
      end
    end
  end

  assign sck = sck_r;
  assign ws  = ws_r;
  assign sd  = sd_r;

endmodule

`default_nettype wire

// File: rtl/aucohl_fifo.sv
// ==== aucohl_fifo : show-ahead synchronous FIFO with flush and occupancy level (rev 1.0) ====
`default_nettype none

module aucohl_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr,
  input  logic          rd,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]   wp;
  logic [AW:0]   rp;
  logic          wr_ok;
  logic          rd_ok;

  assign level = wp - rp;
  assign empty = (level == '0);
  assign full  = level[AW];
  assign rd_ok = rd & ~empty;
  // When full, a simultaneous pop frees the slot the push lands in
  assign wr_ok = wr & (~full | rd_ok);
  assign rdata = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/ahbl_i2s_tx.sv
// ==== ahbl_i2s_tx : AHB-Lite I2S transmitter with TX FIFO, DMA feed and watermark IRQ (rev 1.0) ====
`default_nettype none

module ahbl_i2s_tx
  import ahbl_i2s_tx_pkg::*;
#(
  parameter int         FIFO_AW   = 4,
  parameter logic [7:0] PRESC_RST = 8'd3
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HSEL,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        DMAC_interaction,
  output logic        SCK,
  output logic        WS,
  output logic        SD,
  output logic        IRQ
);

  logic [7:0]       addr_d;
  logic             trans_d;
  logic             write_d;
  logic             sel_d;
  logic             wr_en;
  logic             reg_wr;
  logic             push;
  logic             flush;
  logic             en;
  logic             mono;
  logic             irq_en;
  logic [7:0]       presc;
  logic [4:0]       thresh;
  logic             udr;
  logic             ovf;
  logic             ovf_set;
  logic             ser_pop;
  logic             ser_underrun;
  logic [31:0]      fifo_rdata;
  logic             fifo_empty;
  logic             fifo_full;
  logic [FIFO_AW:0] level;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign unused_bits = ^{HADDR[31:8], HTRANS[0], HSIZE};
  assign HREADYOUT   = 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_d  <= '0;
      trans_d <= 1'b0;
      write_d <= 1'b0;
      sel_d   <= 1'b0;
    end else if (HREADY) begin
      addr_d  <= HADDR[7:0];
      trans_d <= HTRANS[1];
      write_d <= HWRITE;
      sel_d   <= HSEL;
    end
  end

  // DMA writes bypass the register decode entirely
  assign wr_en   = trans_d & sel_d & write_d;
  assign reg_wr  = wr_en & ~DMAC_interaction;
  assign push    = (wr_en & DMAC_interaction) | (reg_wr & (addr_d == OFF_DATA));
  assign flush   = reg_wr & (addr_d == OFF_CTRL) & HWDATA[CTRL_FLUSH];
  assign ovf_set = push & fifo_full & ~ser_pop;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en     <= 1'b0;
      mono   <= 1'b0;
      irq_en <= 1'b0;
      presc  <= PRESC_RST;
      thresh <= '0;
      udr    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (reg_wr && addr_d == OFF_CTRL) begin
        en     <= HWDATA[CTRL_EN];
        mono   <= HWDATA[CTRL_MONO];
        irq_en <= HWDATA[CTRL_IRQ_EN];
      end
      if (reg_wr && addr_d == OFF_PRESCALE) presc  <= HWDATA[7:0];
      if (reg_wr && addr_d == OFF_THRESH)   thresh <= HWDATA[4:0];
      if (ser_underrun)                                           udr <= 1'b1;
      else if (reg_wr && addr_d == OFF_STATUS && HWDATA[2])       udr <= 1'b0;
      if (ovf_set)                                                ovf <= 1'b1;
      else if (reg_wr && addr_d == OFF_STATUS && HWDATA[3])       ovf <= 1'b0;
    end
  end

  always_comb begin
    rdata = RD_DEFAULT;
    case (addr_d)
      OFF_CTRL:     rdata = {28'd0, irq_en, 1'b0, mono, en};
      OFF_STATUS:   rdata = {23'd0, 5'(level), ovf, udr, fifo_full, fifo_empty};
      OFF_DATA:     rdata = '0;
      OFF_PRESCALE: rdata = {24'd0, presc};
      OFF_THRESH:   rdata = {27'd0, thresh};
      default:      rdata = RD_DEFAULT;
    endcase
  end

  assign HRDATA = rdata;
  assign IRQ    = irq_en & (32'(level) <= 32'(thresh));

  aucohl_fifo #(
    .DW (32),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .flush (flush),
    .wr    (push),
    .rd    (ser_pop),
    .wdata (HWDATA),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  i2s_tx_serializer u_ser (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .en         (en),
    .mono       (mono),
    .presc      (presc),
    .fifo_empty (fifo_empty),
    .fifo_word  (fifo_rdata),
    .pop        (ser_pop),
    .underrun   (ser_underrun),
    .sck        (SCK),
    .ws         (WS),
    .sd         (SD)
  );

endmodule

`default_nettype wire

// File: tb/tb_ahbl_i2s_tx.sv
// ==== tb_ahbl_i2s_tx : self-checking bench for the AHB-Lite I2S transmitter (rev 1.0) ====
`default_nettype none

module tb_ahbl_i2s_tx;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [31:0] HWDATA = '0;
  logic        HSEL = 1'b0;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        DMAC_interaction = 1'b0;
  logic        SCK;
  logic        WS;
  logic        SD;
  logic        IRQ;

  always #5 HCLK = ~HCLK;

  ahbl_i2s_tx #(
    .FIFO_AW   (4),
    .PRESC_RST (8'd3)
  ) dut (
    .HCLK             (HCLK),
    .HRESETn          (HRESETn),
    .HADDR            (HADDR),
    .HTRANS           (HTRANS),
    .HWRITE           (HWRITE),
    .HSIZE            (HSIZE),
    .HWDATA           (HWDATA),
    .HSEL             (HSEL),
    .HREADY           (HREADY),
    .HRDATA           (HRDATA),
    .HREADYOUT        (HREADYOUT),
    .DMAC_interaction (DMAC_interaction),
    .SCK              (SCK),
    .WS               (WS),
    .SD               (SD),
    .IRQ              (IRQ)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input bit dma = 1'b0);
    @(negedge HCLK);
    HADDR = a; HTRANS = 2'b10; HWRITE = 1'b1; HSEL = 1'b1; DMAC_interaction = dma;
    @(negedge HCLK);
    HWDATA = d; HTRANS = 2'b00; HWRITE = 1'b0; HSEL = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HADDR = a; HTRANS = 2'b10; HWRITE = 1'b0; HSEL = 1'b1; DMAC_interaction = 1'b0;
    @(negedge HCLK);
    HTRANS = 2'b00; HSEL = 1'b0;
    d = HRDATA;
  endtask

  // Bit-clock monitor: records {WS,SD} at every SCK rising edge, as a DAC would
  logic [1:0] cap[$];
  bit         cap_on = 1'b0;
  bit         have_prev = 1'b0;
  bit         prev_sck = 1'b0;
  int         exp_per = 0;
  int         per_err = 0;
  int         cyc = 0;
  int         last_rise = 0;

  always @(negedge HCLK) begin
    cyc++;
    if (cap_on && SCK && !prev_sck) begin
      if (have_prev && (cyc - last_rise) != exp_per) per_err++;
      have_prev = 1'b1;
      last_rise = cyc;
      cap.push_back({WS, SD});
    end
    prev_sck = SCK;
  end

  logic [31:0] wq[$];

  // Reference: each frame takes the next queued word (or 0) for left, and for right
  // either the next word (stereo) or the left word again (mono).
  task automatic run_frames(input bit mono, input int presc, input int nfr, input string tag);
    logic [31:0] model[$];
    logic [31:0] l, r, w, st;
    logic [1:0]  e;
    int n, need, bad, k, lim, idx, bb;
    n = wq.size();
    bus_write(32'h0C, 32'(presc));
    bus_write(32'h00, 32'h4);
    bus_write(32'h04, 32'hC);
    foreach (wq[i]) bus_write(32'h08, wq[i]);
    model = wq;
    cap.delete(); have_prev = 1'b0; per_err = 0; exp_per = 2 * (presc + 1); cap_on = 1'b1;
    bus_write(32'h00, mono ? 32'h3 : 32'h1);
    lim = 200 * exp_per * nfr;
    k = 0;
    while (cap.size() < 1 + 64 * (nfr - 1) + 10 && k < lim) begin
      @(negedge HCLK);
      k++;
    end
    check({tag, " start_timeout"}, 32'(k < lim), 32'd1);
    bus_write(32'h00, mono ? 32'h2 : 32'h0);
    repeat (70 * exp_per + 20) @(negedge HCLK);
    cap_on = 1'b0;
    // One leading rise precedes the first slot of the first frame
    check({tag, " rises"}, 32'(cap.size()), 32'(1 + 64 * nfr));
    for (int f = 0; f < nfr; f++) begin
      l = (model.size() > 0) ? model.pop_front() : 32'h0;
      if (mono) r = l;
      else      r = (model.size() > 0) ? model.pop_front() : 32'h0;
      bad = 0;
      for (int b = 0; b < 64; b++) begin
        idx = 1 + 64 * f + b;
        w   = (b < 32) ? l : r;
        bb  = 31 - (b % 32);
        e   = {((b >= 31) && (b <= 62)) ? 1'b1 : 1'b0, w[bb]};
        if (idx >= cap.size() || cap[idx] !== e) bad++;
      end
      check($sformatf("%s frame%0d_bits", tag, f), 32'(bad), 32'd0);
    end
    bus_read(32'h04, st);
    need = mono ? nfr : 2 * nfr;
    check({tag, " underrun"}, 32'(st[2]), 32'(need > n));
    check({tag, " level"}, 32'(st[8:4]), 32'((n > need) ? n - need : 0));
    check({tag, " sck_period"}, 32'(per_err), 32'd0);
    check({tag, " idle_pins"}, {29'd0, SCK, WS, SD}, 32'd0);
  endtask

  typedef struct {
    bit          rd;
    bit          dma;
    logic [7:0]  addr;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [31:0] rv;
    int k;

    vt.push_back('{1'b1, 1'b0, 8'h00, 32'h0000_0000, "ctrl_rst"});
    vt.push_back('{1'b1, 1'b0, 8'h04, 32'h0000_0001, "status_rst"});
    vt.push_back('{1'b1, 1'b0, 8'h0C, 32'h0000_0003, "presc_rst"});
    vt.push_back('{1'b1, 1'b0, 8'h10, 32'h0000_0000, "thresh_rst"});
    vt.push_back('{1'b1, 1'b0, 8'h08, 32'h0000_0000, "data_reads0"});
    vt.push_back('{1'b1, 1'b0, 8'h20, 32'hBADD_BEEF, "unmapped"});
    vt.push_back('{1'b0, 1'b0, 8'h0C, 32'h0000_01FF, ""});
    vt.push_back('{1'b1, 1'b0, 8'h0C, 32'h0000_00FF, "presc_mask"});
    vt.push_back('{1'b0, 1'b0, 8'h10, 32'hFFFF_FFFF, ""});
    vt.push_back('{1'b1, 1'b0, 8'h10, 32'h0000_001F, "thresh_mask"});
    vt.push_back('{1'b0, 1'b0, 8'h00, 32'h0000_000E, ""});
    vt.push_back('{1'b1, 1'b0, 8'h00, 32'h0000_000A, "ctrl_rw"});
    vt.push_back('{1'b0, 1'b0, 8'h00, 32'h0000_0000, ""});
    vt.push_back('{1'b0, 1'b1, 8'h00, 32'h1234_5678, ""});
    vt.push_back('{1'b1, 1'b0, 8'h00, 32'h0000_0000, "dma_ctrl_kept"});
    vt.push_back('{1'b1, 1'b0, 8'h04, 32'h0000_0010, "dma_pushed"});
    vt.push_back('{1'b0, 1'b0, 8'h08, 32'h0000_CAFE, ""});
    vt.push_back('{1'b1, 1'b0, 8'h04, 32'h0000_0020, "data_pushed"});
    vt.push_back('{1'b0, 1'b0, 8'h00, 32'h0000_0004, ""});
    vt.push_back('{1'b1, 1'b0, 8'h04, 32'h0000_0001, "flush"});
    vt.push_back('{1'b1, 1'b0, 8'h00, 32'h0000_0000, "flush_reads0"});

    repeat (3) @(negedge HCLK);
    check("rst_pins", {27'd0, HREADYOUT, SCK, WS, SD, IRQ}, 32'h10);
    HRESETn = 1'b1;

    foreach (vt[i]) begin
      if (vt[i].rd) begin
        bus_read({24'd0, vt[i].addr}, rv);
        check(vt[i].name, rv, vt[i].data);
      end else begin
        bus_write({24'd0, vt[i].addr}, vt[i].data, vt[i].dma);
      end
    end

    // Overflow: 17 pushes with the serializer off; flush keeps the sticky bit
    for (int i = 0; i < 17; i++) bus_write(32'h08, 32'(i));
    bus_read(32'h04, rv);  check("ovf_status", rv, 32'h0000_010A);
    bus_write(32'h00, 32'h4);
    bus_read(32'h04, rv);  check("flush_keeps_sticky", rv, 32'h0000_0009);
    bus_write(32'h04, 32'h8);
    bus_read(32'h04, rv);  check("ovf_w1c", rv, 32'h0000_0001);

    wq = '{32'hA5A5_0001, 32'h5A5A_0002};
    run_frames(1'b0, 1, 1, "stereo");

    wq = '{32'h8000_0001};
    run_frames(1'b1, 0, 2, "mono");
    bus_write(32'h04, 32'h4);
    bus_read(32'h04, rv);  check("underrun_w1c", rv, 32'h0000_0001);

    for (int t = 0; t < 6; t++) begin
      int n;
      wq.delete();
      n = $urandom_range(0, 16);
      for (int i = 0; i < n; i++) wq.push_back($urandom());
      run_frames(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(1, 3),
                 $sformatf("rand%0d", t));
    end

    // Watermark IRQ: must rise at the right-channel pop that takes the level to 2
    bus_write(32'h00, 32'h4);
    bus_write(32'h04, 32'hC);
    bus_write(32'h10, 32'h2);
    bus_write(32'h0C, 32'd15);
    for (int i = 0; i < 4; i++) bus_write(32'h08, 32'h1111_0000 + 32'(i));
    bus_write(32'h00, 32'h8);
    @(negedge HCLK);
    check("irq_low_at_4", 32'(IRQ), 32'd0);
    cap.delete(); have_prev = 1'b0; per_err = 0; exp_per = 32; cap_on = 1'b1;
    bus_write(32'h00, 32'h9);
    k = 0;
    while (!IRQ && k < 8000) begin
      @(negedge HCLK);
      k++;
    end
    check("irq_rise_seen", 32'(IRQ), 32'd1);
    check("irq_rise_at_right_load", 32'(cap.size()), 32'd33);
    bus_read(32'h04, rv);  check("irq_level2", rv, 32'h0000_0020);
    bus_write(32'h08, 32'h2222_0000);
    bus_write(32'h08, 32'h2222_0001);
    @(negedge HCLK);
    check("irq_low_after_refill", 32'(IRQ), 32'd0);
    bus_write(32'h00, 32'h8);
    repeat (70 * 32 + 20) @(negedge HCLK);
    cap_on = 1'b0;
    check("irq_run_stopped", {29'd0, SCK, WS, SD}, 32'd0);
    bus_write(32'h00, 32'h4);

    // Asynchronous reset in the middle of the right slot
    bus_write(32'h10, 32'h1F);
    bus_write(32'h0C, 32'd1);
    for (int i = 0; i < 4; i++) bus_write(32'h08, 32'hF0F0_0000 + 32'(i));
    cap.delete(); have_prev = 1'b0; exp_per = 4; cap_on = 1'b1;
    bus_write(32'h00, 32'h9);
    k = 0;
    while (cap.size() < 41 && k < 2000) begin
      @(negedge HCLK);
      k++;
    end
    check("rst_midframe_reached", 32'(cap.size() >= 41), 32'd1);
    check("pre_rst_ws_irq", {30'd0, WS, IRQ}, 32'h3);
    #1 HRESETn = 1'b0;
    #1 check("async_rst_pins", {28'd0, SCK, WS, SD, IRQ}, 32'd0);
    cap_on = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    bus_read(32'h04, rv);  check("post_rst_status", rv, 32'h0000_0001);
    bus_read(32'h00, rv);  check("post_rst_ctrl", rv, 32'h0000_0000);
    bus_read(32'h0C, rv);  check("post_rst_presc", rv, 32'h0000_0003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
